mem_stage_ctrl: RTL

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// mem_stage_ctrl: MEM-stage data-cache access sequencer (IDLE -> ACCESS -> DONE).
// Define MEM_MISALIGN_CHECK_EN to trap misaligned accesses instead of force-aligning them.
module mem_stage_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_valid,
  input  logic        MEM_mem_read,
  input  logic        MEM_mem_write,
  input  logic [2:0]  MEM_funct3,
  input  logic [31:0] MEM_alu_out,
  input  logic [31:0] MEM_rs2_out,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        mem_stall,
  output logic [31:0] MEM_rdata,
  output logic        MEM_rdata_valid,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t      state_q   = IDLE;
  logic        read_q    = 1'b0;
  logic        write_q   = 1'b0;
  logic [31:0] addr_q    = 32'd0;
  logic [31:0] wdata_q   = 32'd0;
  logic [3:0]  be_q      = 4'd0;
  logic [1:0]  off_q     = 2'd0;
  logic [1:0]  size_q    = SZ_B;
  logic        uns_q     = 1'b0;
  logic [31:0] rdata_q   = 32'd0;
  logic        rvalid_q  = 1'b0;

  logic        req;
  logic        is_byte;
  logic        is_half;
  logic [1:0]  size_d;
  logic [1:0]  off_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [15:0] lane;
  logic [31:0] load_d;

  assign req     = MEM_valid & (MEM_mem_read | MEM_mem_write);
  // Low funct3 bits give the size; reserved encodings fall through to word.
  assign is_byte = (MEM_funct3[1:0] == 2'b00);
  assign is_half = (MEM_funct3[1:0] == 2'b01);
  assign size_d  = is_byte ? SZ_B : (is_half ? SZ_H : SZ_W);
  assign off_d   = is_byte ? MEM_alu_out[1:0] : (is_half ? {MEM_alu_out[1], 1'b0} : 2'b00);
  assign be_d    = is_byte ? (4'b0001 << off_d) : (is_half ? (4'b0011 << off_d) : 4'b1111);
  assign wdata_d = MEM_rs2_out << {off_d, 3'b000};

  always_comb begin
    lane   = 16'(dmem_rdata >> {off_q, 3'b000});
    load_d = dmem_rdata;
    case (size_q)
      SZ_B:    load_d = {{24{~uns_q & lane[7]}}, lane[7:0]};
      SZ_H:    load_d = {{16{~uns_q & lane[15]}}, lane};
      default: load_d = dmem_rdata;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misaligned_d;
  logic misalign_q = 1'b0;
  assign misaligned_d = (is_half & MEM_alu_out[0]) | (~is_byte & ~is_half & (|MEM_alu_out[1:0]));
  assign misalign     = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      off_q    <= 2'd0;
      size_q   <= SZ_B;
      uns_q    <= 1'b0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      rvalid_q <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
`ifdef MEM_MISALIGN_CHECK_EN
          if (req && misaligned_d) begin
            state_q    <= DONE;
            rvalid_q   <= 1'b1;
            misalign_q <= 1'b1;
            rdata_q    <= 32'd0;
          end else
`endif
          if (req) begin
            // A simultaneous read and write is serviced as a read only.
            state_q <= ACCESS;
            read_q  <= MEM_mem_read;
            write_q <= ~MEM_mem_read;
            addr_q  <= {MEM_alu_out[31:2], 2'b00};
            wdata_q <= wdata_d;
            be_q    <= MEM_mem_read ? 4'b0000 : be_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= MEM_funct3[2];
          end
        end
        ACCESS: begin
          if (dmem_resp) begin
            state_q  <= DONE;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            rvalid_q <= 1'b1;
            if (read_q) rdata_q <= load_d;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_stall        = (state_q == ACCESS) | ((state_q == IDLE) & req);
  assign dmem_read        = read_q;
  assign dmem_write       = write_q;
  assign dmem_address     = addr_q;
  assign dmem_wdata       = wdata_q;
  assign dmem_byte_enable = be_q;
  assign MEM_rdata        = rdata_q;
  assign MEM_rdata_valid  = rvalid_q;

endmodule
`default_nettype wire
